// File: rtl/type_pkg.sv
// type_pkg: shared types for the read-response path.
//   burst_size_t  - encoded read burst size (1/2/4/8 bytes)
//   resp_state_t  - read_response_assembler FSM states
//   beat_count()  - number of data bytes (beats) for a burst size
//   byte_mask()   - 64-bit mask keeping only the bytes of a burst size
package type_pkg;

    typedef enum logic [1:0] {
        ONE_BYTE    = 2'd0,
        TWO_BYTES   = 2'd1,
        FOUR_BYTES  = 2'd2,
        EIGHT_BYTES = 2'd3
    } burst_size_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } resp_state_t;

    function automatic logic [3:0] beat_count(input burst_size_t size);
        return 4'd1 << size;
    endfunction

    function automatic logic [63:0] byte_mask(input burst_size_t size);
        logic [63:0] mask;
        mask = '0;
        case (size)
            ONE_BYTE:    mask = 64'h0000_0000_0000_00FF;
            TWO_BYTES:   mask = 64'h0000_0000_0000_FFFF;
            FOUR_BYTES:  mask = 64'h0000_0000_FFFF_FFFF;
            EIGHT_BYTES: mask = '1;
            default:     mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: generic synchronous show-ahead FIFO.
//   clk, n_rst       - clock, asynchronous active-low reset
//   push, push_data  - write request and data (accepted when not full,
//                      or when full with a same-cycle pop)
//   pop              - read request (ignored when empty)
//   pop_data         - head entry, valid while !empty
//   full, empty      - occupancy flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/read_response_assembler.sv
// read_response_assembler: pairs issued read tags with their returning data
// (byte-serial DDR beats or a single RAW-forwarded word) and queues the
// assembled responses for the consumer.
//   clk, n_rst                          - clock, asynchronous active-low reset
//   tid_strobe, tid_pop,
//   rburst_size_pop, tag_raw            - tag push (id, burst size, RAW flag)
//   ddr_rvalid, ddr_rdata               - one DDR data byte per valid cycle
//   raw_valid, raw_data                 - forwarded write data, right-aligned
//   resp_valid, resp_ready              - response handshake
//   resp_tid, resp_data, resp_size      - response contents
//   pend_full                           - pending-tag queue full
//   resp_err                            - one-cycle pulse on a protocol error
module read_response_assembler
    import type_pkg::*;
#(
    parameter int TID_SIZE   = 2,
    parameter int PEND_DEPTH = 8,
    parameter int RESP_DEPTH = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                tid_strobe,
    input  logic [TID_SIZE-1:0] tid_pop,
    input  burst_size_t         rburst_size_pop,
    input  logic                tag_raw,
    input  logic                ddr_rvalid,
    input  logic [7:0]          ddr_rdata,
    input  logic                raw_valid,
    input  logic [63:0]         raw_data,
    input  logic                resp_ready,
    output logic                resp_valid,
    output logic [TID_SIZE-1:0] resp_tid,
    output logic [63:0]         resp_data,
    output burst_size_t         resp_size,
    output logic                pend_full,
    output logic                resp_err
);

    localparam int PW = TID_SIZE + 3;
    localparam int RW = TID_SIZE + 66;

    resp_state_t         state;
    logic [TID_SIZE-1:0] wk_tid;
    burst_size_t         wk_size;
    logic                wk_raw;
    logic [2:0]          beat_cnt;
    logic [63:0]         acc;

    logic [PW-1:0] pend_head;
    logic          pend_empty;
    logic          pend_pop;
    logic [RW-1:0] resp_head;
    logic          resp_full;
    logic          resp_empty;
    logic          resp_push;
    logic          resp_pop;
    logic          emit_ok;
    logic          pend_drop;
    logic          data_err;
    logic          last_beat;

    assign pend_pop  = (state == IDLE) && !pend_empty;
    assign pend_drop = tid_strobe && pend_full && !pend_pop;

    sync_fifo #(
        .WIDTH (PW),
        .DEPTH (PEND_DEPTH)
    ) u_pend_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (tid_strobe),
        .push_data ({tid_pop, rburst_size_pop, tag_raw}),
        .pop       (pend_pop),
        .pop_data  (pend_head),
        .full      (pend_full),
        .empty     (pend_empty)
    );

    assign resp_valid = !resp_empty;
    assign resp_pop   = resp_valid && resp_ready;
    assign resp_push  = (state == EMIT);
    // A full response FIFO still takes the push when the consumer pops in
    // the same cycle, so EMIT only stalls when no slot frees up.
    assign emit_ok    = !resp_full || resp_pop;

    sync_fifo #(
        .WIDTH (RW),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (resp_push),
        .push_data ({wk_tid, acc, wk_size}),
        .pop       (resp_pop),
        .pop_data  (resp_head),
        .full      (resp_full),
        .empty     (resp_empty)
    );

    assign resp_tid  = resp_head[RW-1:66];
    assign resp_data = resp_head[65:2];
    assign resp_size = burst_size_t'(resp_head[1:0]);

    assign last_beat = ({1'b0, beat_cnt} + 4'd1) == beat_count(wk_size);

    // Data on the wrong path, data with nothing to attach it to, or DDR
    // beats while the previous response is still waiting to be queued.
    always_comb begin
        data_err = 1'b0;
        case (state)
            IDLE:    data_err = pend_empty && (ddr_rvalid || raw_valid);
            COLLECT: data_err = wk_raw ? ddr_rvalid : raw_valid;
            EMIT:    data_err = ddr_rvalid;
            default: data_err = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            wk_tid   <= '0;
            wk_size  <= ONE_BYTE;
            wk_raw   <= 1'b0;
            beat_cnt <= '0;
            acc      <= '0;
            resp_err <= 1'b0;
        end else begin
            resp_err <= pend_drop || data_err;
            case (state)
                IDLE: begin
                    if (!pend_empty) begin
                        wk_tid   <= pend_head[PW-1:3];
                        wk_size  <= burst_size_t'(pend_head[2:1]);
                        wk_raw   <= pend_head[0];
                        beat_cnt <= '0;
                        acc      <= '0;
                        state    <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (wk_raw) begin
                        if (raw_valid) begin
                            acc   <= raw_data & byte_mask(wk_size);
                            state <= EMIT;
                        end
                    end else if (ddr_rvalid) begin
                        acc[{beat_cnt, 3'b000} +: 8] <= ddr_rdata;
                        beat_cnt <= beat_cnt + 3'd1;
                        if (last_beat) begin
                            state <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (emit_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_read_response_assembler.sv
// tb_read_response_assembler: directed scenarios plus a randomized run,
// checked against a transaction-level queue of expected responses.
module tb_read_response_assembler;
    import type_pkg::*;

    typedef struct {
        logic [1:0]  tid;
        logic [63:0] data;
        burst_size_t size;
    } resp_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        tid_strobe;
    logic [1:0]  tid_pop;
    burst_size_t rburst_size_pop;
    logic        tag_raw;
    logic        ddr_rvalid;
    logic [7:0]  ddr_rdata;
    logic        raw_valid;
    logic [63:0] raw_data;
    logic        resp_ready;
    logic        resp_valid;
    logic [1:0]  resp_tid;
    logic [63:0] resp_data;
    burst_size_t resp_size;
    logic        pend_full;
    logic        resp_err;

    int    checks   = 0;
    int    failures = 0;
    int    err_cnt  = 0;
    int    e0;
    bit    rand_ready = 1'b0;
    resp_t exp_q[$];

    always #5 clk = ~clk;

    read_response_assembler #(
        .TID_SIZE   (2),
        .PEND_DEPTH (8),
        .RESP_DEPTH (4)
    ) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .tid_strobe      (tid_strobe),
        .tid_pop         (tid_pop),
        .rburst_size_pop (rburst_size_pop),
        .tag_raw         (tag_raw),
        .ddr_rvalid      (ddr_rvalid),
        .ddr_rdata       (ddr_rdata),
        .raw_valid       (raw_valid),
        .raw_data        (raw_data),
        .resp_ready      (resp_ready),
        .resp_valid      (resp_valid),
        .resp_tid        (resp_tid),
        .resp_data       (resp_data),
        .resp_size       (resp_size),
        .pend_full       (pend_full),
        .resp_err        (resp_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs are set at a falling edge; any handshake they set up happens at
    // the next rising edge, so it is checked here before waiting.
    task automatic step();
        resp_t e;
        if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("resp_tid", 64'(resp_tid), 64'(e.tid));
                check("resp_data", resp_data, e.data);
                check("resp_size", 64'(resp_size), 64'(e.size));
            end
        end
        @(negedge clk);
        if (resp_err) err_cnt++;
        tid_strobe = 1'b0;
        ddr_rvalid = 1'b0;
        raw_valid  = 1'b0;
        if (rand_ready) resp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_tag(input logic [1:0] tid, input burst_size_t size, input logic raw);
        tid_strobe      = 1'b1;
        tid_pop         = tid;
        rburst_size_pop = size;
        tag_raw         = raw;
        step();
    endtask

    task automatic ddr_byte(input logic [7:0] b);
        ddr_rvalid = 1'b1;
        ddr_rdata  = b;
        step();
    endtask

    task automatic expect_resp(input logic [1:0] tid, input logic [63:0] data, input burst_size_t size);
        resp_t r;
        r.tid  = tid;
        r.data = data;
        r.size = size;
        exp_q.push_back(r);
    endtask

    task automatic drain();
        rand_ready = 1'b0;
        resp_ready = 1'b1;
        for (int g = 0; g < 200 && exp_q.size() > 0; g++) step();
        check("drain_done", 64'(exp_q.size()), 64'd0);
        check("drain_valid_low", 64'(resp_valid), 64'd0);
    endtask

    initial begin
        n_rst           = 1'b0;
        tid_strobe      = 1'b0;
        tid_pop         = '0;
        rburst_size_pop = ONE_BYTE;
        tag_raw         = 1'b0;
        ddr_rvalid      = 1'b0;
        ddr_rdata       = '0;
        raw_valid       = 1'b0;
        raw_data        = '0;
        resp_ready      = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(resp_valid), 64'd0);
        check("rst_pend_full", 64'(pend_full), 64'd0);
        check("rst_err", 64'(resp_err), 64'd0);
        check("rst_tid", 64'(resp_tid), 64'd0);
        check("rst_data", resp_data, 64'd0);
        check("rst_size", 64'(resp_size), 64'(ONE_BYTE));
        n_rst = 1'b1;
        idle(2);

        // Eight DDR beats, one-cycle latency to resp_valid
        e0 = err_cnt;
        push_tag(2'd2, EIGHT_BYTES, 1'b0);
        idle(2);
        for (int i = 0; i < 8; i++) ddr_byte(8'(8'h11 * (i + 1)));
        check("lat_not_yet", 64'(resp_valid), 64'd0);
        step();
        check("lat_valid", 64'(resp_valid), 64'd1);
        check("eight_data", resp_data, 64'h8877665544332211);
        check("eight_tid", 64'(resp_tid), 64'd2);
        expect_resp(2'd2, 64'h8877665544332211, EIGHT_BYTES);
        drain();

        // RAW-forwarded two-byte read
        resp_ready = 1'b0;
        push_tag(2'd1, TWO_BYTES, 1'b1);
        idle(2);
        raw_valid = 1'b1;
        raw_data  = 64'hDEAD_BEEF;
        step();
        step();
        check("raw_data", resp_data, 64'h0000_0000_0000_BEEF);
        check("raw_tid", 64'(resp_tid), 64'd1);
        expect_resp(2'd1, 64'hBEEF, TWO_BYTES);
        drain();
        check("clean_errs", 64'(err_cnt - e0), 64'd0);

        // Pending queue overflow: one tag held in the working register,
        // then nine more strobes; the ninth must be dropped.
        e0 = err_cnt;
        push_tag(2'd0, ONE_BYTE, 1'b0);
        idle(3);
        for (int i = 0; i < 9; i++) begin
            push_tag(2'(i), ONE_BYTE, 1'b0);
            if (i == 6) check("pend_not_full_7", 64'(pend_full), 64'd0);
            if (i == 7) check("pend_full_8", 64'(pend_full), 64'd1);
        end
        check("overflow_err", 64'(err_cnt - e0), 64'd1);
        check("pend_full_kept", 64'(pend_full), 64'd1);
        expect_resp(2'd0, 64'hA0, ONE_BYTE);
        for (int i = 0; i < 8; i++) expect_resp(2'(i), 64'(8'hA1 + i), ONE_BYTE);
        resp_ready = 1'b1;
        for (int j = 0; j < 9; j++) begin
            ddr_byte(8'(8'hA0 + j));
            idle(3);
        end
        check("overflow_resps", 64'(exp_q.size()), 64'd0);
        check("pend_drained", 64'(pend_full), 64'd0);

        // Stray DDR beat with nothing pending
        e0 = err_cnt;
        ddr_byte(8'h77);
        idle(3);
        check("stray_err", 64'(err_cnt - e0), 64'd1);
        check("stray_no_resp", 64'(resp_valid), 64'd0);

        // Response FIFO back-pressure: four buffered, fifth waits
        e0 = err_cnt;
        resp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_tag(2'(i), ONE_BYTE, 1'b0);
        idle(2);
        for (int i = 0; i < 5; i++) begin
            ddr_byte(8'(8'h30 + i));
            expect_resp(2'(i), 64'(8'h30 + i), ONE_BYTE);
            idle(3);
        end
        check("bp_valid", 64'(resp_valid), 64'd1);
        check("bp_head_stable", resp_data, 64'h30);
        check("bp_errs", 64'(err_cnt - e0), 64'd0);
        drain();

        // Reset mid-collection discards partial data and pending tags
        push_tag(2'd3, EIGHT_BYTES, 1'b0);
        push_tag(2'd1, FOUR_BYTES, 1'b0);
        idle(2);
        for (int i = 0; i < 3; i++) ddr_byte(8'(8'hC0 + i));
        n_rst = 1'b0;
        idle(2);
        check("mid_rst_valid", 64'(resp_valid), 64'd0);
        check("mid_rst_pend", 64'(pend_full), 64'd0);
        n_rst = 1'b1;
        idle(1);
        e0 = err_cnt;
        push_tag(2'd2, ONE_BYTE, 1'b0);
        idle(2);
        ddr_byte(8'h5A);
        expect_resp(2'd2, 64'h5A, ONE_BYTE);
        idle(2);
        drain();

        // Randomized transactions with random consumer back-pressure
        rand_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            logic [1:0]  tid;
            burst_size_t sz;
            logic        raw;
            logic [63:0] word;
            logic [63:0] exp;
            int          n;
            int          g;
            g = 0;
            while (exp_q.size() >= 4 && g < 300) begin
                step();
                g++;
            end
            if (g >= 300) check("rand_wait_timeout", 64'd1, 64'd0);
            tid  = 2'($urandom_range(0, 3));
            sz   = burst_size_t'($urandom_range(0, 3));
            raw  = 1'($urandom_range(0, 1));
            word = {$urandom, $urandom};
            n    = 1 << int'(sz);
            exp  = '0;
            push_tag(tid, sz, raw);
            idle(2);
            if (raw) begin
                raw_valid = 1'b1;
                raw_data  = word;
                step();
            end else begin
                for (int b = 0; b < n; b++) begin
                    ddr_byte(word[8*b +: 8]);
                    if ($urandom_range(0, 1) == 1) step();
                end
            end
            for (int b = 0; b < n; b++) exp[8*b +: 8] = word[8*b +: 8];
            expect_resp(tid, exp, sz);
        end
        idle(2);
        drain();
        check("rand_errs", 64'(err_cnt - e0), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
